// File: rtl/axis_integrator.sv
// ============================================================================
// axis_integrator
//
// Streaming integrator with an optional leak. The design sits between an
// AXI-Stream slave and master port. Each accepted input sample is added into
// a signed accumulator. The shifted accumulator value, or the raw sample in
// bypass mode, appears on the output one cycle later through a one-entry
// output register.
//
// Parameters:
//   AXIS_TDATA_WIDTH : sample width (signed two's complement), in and out
//   ACC_WIDTH        : accumulator width, at least AXIS_TDATA_WIDTH+1
//   OUT_SHIFT        : arithmetic right shift from accumulator to output
//   LEAK_SHIFT       : leak coefficient 2^-LEAK_SHIFT, 0 disables the leak
//
// Ports:
//   aclk, aresetn         : clock, asynchronous active-low reset
//   enable                : 1 = integrate, 0 = bypass the sample
//   clear                 : synchronous level-sensitive accumulator clear
//   S_AXIS_tvalid/tdata   : input stream
//   S_AXIS_tready         : input accepted when output slot is free/draining
//   M_AXIS_tvalid/tdata   : output stream
//   M_AXIS_tready         : downstream accepts the output
//
// Optional feature:
//   AXIS_INTEGRATOR_SATURATE_EN : when defined, the accumulator and the
//   shifted output saturate instead of wrapping.
// ============================================================================
module axis_integrator #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int ACC_WIDTH        = 32,
    parameter int OUT_SHIFT        = 0,
    parameter int LEAK_SHIFT       = 0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

    localparam int TW = AXIS_TDATA_WIDTH;
    localparam int AW = ACC_WIDTH;

    logic signed [AW-1:0] r_acc;
    logic                 r_mValid;
    logic [TW-1:0]        r_mData;

    logic                 w_sReady;
    logic                 w_accept;
    logic signed [AW-1:0] w_sext;
    logic signed [AW-1:0] w_leak;
    logic signed [AW-1:0] w_accSum;
    logic signed [AW-1:0] w_accNext;
    logic [TW-1:0]        w_outData;

    // The output slot can take a new beat when it is empty or draining this cycle.
    assign w_sReady      = aresetn && (!r_mValid || M_AXIS_tready);
    assign w_accept      = S_AXIS_tvalid && w_sReady;
    assign S_AXIS_tready = w_sReady;
    assign M_AXIS_tvalid = r_mValid;
    assign M_AXIS_tdata  = r_mData;

    assign w_sext = {{(AW-TW){S_AXIS_tdata[TW-1]}}, S_AXIS_tdata};

    generate
        if (LEAK_SHIFT > 0) begin : g_leak
            assign w_leak = r_acc >>> LEAK_SHIFT;
        end else begin : g_noLeak
            assign w_leak = '0;
        end
    endgenerate

`ifdef AXIS_INTEGRATOR_SATURATE_EN
    // acc - leak never leaves the accumulator range, so one extra bit is
    // enough to see an overflow from adding the sample.
    logic signed [AW:0]   w_accWide;
    logic signed [AW-1:0] w_shifted;

    assign w_accWide = {r_acc[AW-1], r_acc} - {w_leak[AW-1], w_leak}
                     + {w_sext[AW-1], w_sext};

    always_comb begin
        w_accSum = w_accWide[AW-1:0];
        if (w_accWide[AW] != w_accWide[AW-1]) begin
            w_accSum = w_accWide[AW] ? {1'b1, {(AW-1){1'b0}}}
                                     : {1'b0, {(AW-1){1'b1}}};
        end
    end

    assign w_accNext = clear ? w_sext : w_accSum;
    assign w_shifted = w_accNext >>> OUT_SHIFT;

    // In range only when every bit above the output sign bit matches it.
    always_comb begin
        w_outData = w_shifted[TW-1:0];
        if (!((&w_shifted[AW-1:TW-1]) || !(|w_shifted[AW-1:TW-1]))) begin
            w_outData = w_shifted[AW-1] ? {1'b1, {(TW-1){1'b0}}}
                                        : {1'b0, {(TW-1){1'b1}}};
        end
    end
`else
    assign w_accSum  = r_acc - w_leak + w_sext;
    assign w_accNext = clear ? w_sext : w_accSum;
    assign w_outData = TW'(w_accNext >>> OUT_SHIFT);
`endif

    // Accumulator and output register. A load and a drain in the same cycle
    // simply reloads the slot, so beats can follow back to back. A clear that
    // arrives without a beat zeroes only the accumulator. Any pending output
    // stays untouched.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_acc    <= '0;
            r_mValid <= 1'b0;
            r_mData  <= '0;
        end else begin
            if (w_accept) begin
                r_mValid <= 1'b1;
                r_mData  <= enable ? w_outData : S_AXIS_tdata;
                if (clear || enable) begin
                    r_acc <= w_accNext;
                end
            end else begin
                if (M_AXIS_tready) begin
                    r_mValid <= 1'b0;
                end
                if (clear) begin
                    r_acc <= '0;
                end
            end
        end
    end

endmodule
